// File: rtl/inducer_conditioner.sv
// Debounces the two raw inducer lines into a committed r1/r0 pair for the NOR-network stage.
// Optional macro INDUCER_SYNC_EN adds a 2-flop synchronizer per line (otherwise a single capture flop).
module inducer_conditioner #(
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw_r1,
  input  logic       raw_r0,
  input  logic       hold,
  output logic       r1,
  output logic       r0,
  output logic       upd,
  output logic       busy,
  output logic [7:0] n_changes
);

  typedef enum logic {STABLE, SETTLE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

  state_t           state;
  logic [1:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       s;

`ifdef INDUCER_SYNC_EN
  logic [1:0] sync_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 2'b00;
      s         <= 2'b00;
    end else begin
      sync_meta <= {raw_r1, raw_r0};
      s         <= sync_meta;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= 2'b00;
    end else begin
      s <= {raw_r1, raw_r0};
    end
  end
`endif

  // r1 and r0 are always written as one pair so the logic stage never sees a mixed combination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= STABLE;
      cand      <= 2'b00;
      cnt       <= '0;
      r1        <= 1'b0;
      r0        <= 1'b0;
      upd       <= 1'b0;
      n_changes <= 8'd0;
    end else begin
      upd <= 1'b0;
      case (state)
        STABLE: begin
          if (!hold && (s != {r1, r0})) begin
            if (STABLE_CYCLES == 1) begin
              {r1, r0} <= s;
              upd      <= 1'b1;
              if (n_changes != 8'hff) n_changes <= n_changes + 8'd1;
            end else begin
              cand  <= s;
              cnt   <= CNT_W'(1);
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (!hold) begin
            if (s == {r1, r0}) begin
              state <= STABLE;
              cnt   <= '0;
            end else if (s != cand) begin
              cand <= s;
              cnt  <= CNT_W'(1);
            end else if (cnt == LAST_CNT) begin
              {r1, r0} <= cand;
              upd      <= 1'b1;
              if (n_changes != 8'hff) n_changes <= n_changes + 8'd1;
              state    <= STABLE;
              cnt      <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= STABLE;
      endcase
    end
  end

  assign busy = (state == SETTLE);

endmodule

// File: tb/tb_inducer_conditioner.sv
// Self-checking bench for inducer_conditioner: a default-window instance and a one-cycle-window
// instance, both compared every cycle against a streak-counting reference model.
module tb_inducer_conditioner;

`ifdef INDUCER_SYNC_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif
  localparam int N0 = 8;
  localparam int N1 = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] raw0 = 2'b00;
  logic [1:0] raw1 = 2'b00;
  logic       hold0 = 1'b0;
  logic       hold1 = 1'b0;

  logic       r1a, r0a, upda, busya;
  logic [7:0] nca;
  logic       r1b, r0b, updb, busyb;
  logic [7:0] ncb;

  int checks = 0;
  int failures = 0;

  // Reference model state, index 0 = default window, index 1 = one-cycle window
  logic [1:0] pipe [2][2];
  logic [1:0] mOut [2];
  logic [1:0] sVal [2];
  int         sLen [2];
  int         mCnt [2];
  logic       mUpd [2];

  inducer_conditioner #(.STABLE_CYCLES(N0), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .raw_r1(raw0[1]), .raw_r0(raw0[0]), .hold(hold0),
    .r1(r1a), .r0(r0a), .upd(upda), .busy(busya), .n_changes(nca)
  );

  inducer_conditioner #(.STABLE_CYCLES(N1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .raw_r1(raw1[1]), .raw_r0(raw1[0]), .hold(hold1),
    .r1(r1b), .r0(r0b), .upd(updb), .busy(busyb), .n_changes(ncb)
  );

  always #5 clk = ~clk;

  function automatic void modelReset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2; i++) pipe[k][i] = 2'b00;
      mOut[k] = 2'b00;
      sVal[k] = 2'b00;
      sLen[k] = 0;
      mCnt[k] = 0;
      mUpd[k] = 1'b0;
    end
  endfunction

  // A value commits once it has been seen for n consecutive non-hold samples while differing from the output.
  function automatic void modelStep(int k, int n, logic [1:0] raw, logic h);
    logic [1:0] sv;
    sv = pipe[k][D-1];
    for (int i = D - 1; i > 0; i--) pipe[k][i] = pipe[k][i-1];
    pipe[k][0] = raw;
    mUpd[k] = 1'b0;
    if (!h) begin
      if (sv == mOut[k]) begin
        sLen[k] = 0;
      end else begin
        if (sLen[k] > 0 && sv == sVal[k]) begin
          sLen[k]++;
        end else begin
          sVal[k] = sv;
          sLen[k] = 1;
        end
        if (sLen[k] == n) begin
          mOut[k] = sv;
          mUpd[k] = 1'b1;
          sLen[k] = 0;
          if (mCnt[k] < 255) mCnt[k]++;
        end
      end
    end
  endfunction

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkVal("a_pair", {6'd0, r1a, r0a}, {6'd0, mOut[0]});
    checkVal("a_upd", {7'd0, upda}, {7'd0, mUpd[0]});
    checkVal("a_busy", {7'd0, busya}, {7'd0, (sLen[0] > 0)});
    checkVal("a_count", nca, 8'(mCnt[0]));
    checkVal("b_pair", {6'd0, r1b, r0b}, {6'd0, mOut[1]});
    checkVal("b_upd", {7'd0, updb}, {7'd0, mUpd[1]});
    checkVal("b_busy", {7'd0, busyb}, {7'd0, (sLen[1] > 0)});
    checkVal("b_count", ncb, 8'(mCnt[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      modelStep(0, N0, raw0, hold0);
      modelStep(1, N1, raw1, hold1);
    end
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic h, input int cycles);
    raw0  = r;
    hold0 = h;
    repeat (cycles) tick();
  endtask

  task automatic doReset(input logic [1:0] r);
    rst_n = 1'b0;
    raw0  = r;
    hold0 = 1'b0;
    modelReset();
    #1;
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    modelReset();
    #2;
    doReset(2'b00);
    checkVal("reset_count", nca, 8'd0);

    // Clean step: commit lands exactly on edge D+N0
    applyStimulus(2'b10, 1'b0, D + N0 - 1);
    checkVal("clean_pre", {6'd0, r1a, r0a}, 8'h00);
    applyStimulus(2'b10, 1'b0, 1);
    checkVal("clean_commit", {6'd0, r1a, r0a}, 8'h02);
    checkVal("clean_count", nca, 8'd1);
    applyStimulus(2'b10, 1'b0, 2);

    // Back to 00, then a short 11 glitch
    applyStimulus(2'b00, 1'b0, D + N0 + 2);
    applyStimulus(2'b11, 1'b0, 5);
    applyStimulus(2'b00, 1'b0, D + 4);
    checkVal("glitch_pair", {6'd0, r1a, r0a}, 8'h00);
    checkVal("glitch_busy", {7'd0, busya}, 8'h00);

    // Candidate switch 01 -> 11
    applyStimulus(2'b01, 1'b0, 4);
    applyStimulus(2'b11, 1'b0, D + N0 + 2);
    checkVal("switch_pair", {6'd0, r1a, r0a}, 8'h03);

    // Hold freeze at cnt=5, commit on the 3rd edge after release
    applyStimulus(2'b00, 1'b0, D + 5);
    applyStimulus(2'b00, 1'b1, 6);
    applyStimulus(2'b00, 1'b0, 2);
    checkVal("hold_pre", {6'd0, r1a, r0a}, 8'h03);
    applyStimulus(2'b00, 1'b0, 1);
    checkVal("hold_commit", {6'd0, r1a, r0a}, 8'h00);

    // Reset at cnt=6 with 11 still applied
    applyStimulus(2'b11, 1'b0, D + 6);
    doReset(2'b11);
    applyStimulus(2'b11, 1'b0, D + N0 - 1);
    checkVal("rst_pre", {6'd0, r1a, r0a}, 8'h00);
    applyStimulus(2'b11, 1'b0, 1);
    checkVal("rst_commit", {6'd0, r1a, r0a}, 8'h03);

    // Randomized segments with occasional hold
    for (int seg = 0; seg < 60; seg++) begin
      applyStimulus(2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
                    int'($urandom_range(1, 12)));
    end
    applyStimulus(2'b00, 1'b0, D + N0 + 2);

    // Saturation on the one-cycle window instance
    for (int t = 0; t < 300; t++) begin
      raw1 = raw1 + 2'($urandom_range(1, 3));
      repeat (int'($urandom_range(2, 3))) tick();
    end
    repeat (D + 2) tick();
    checkVal("sat_count", ncb, 8'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
